nrisc_ula_exec_stage: RTL and testbench

- Execute-stage pipeline block that feeds the combinational ULA and captures what it produces.
- Registers a decoded operation (operands, 4-bit ULA control, destination register, flag-write enable) and drives the ULA inputs from that register.
- Captures the ULA result and flags into a writeback register, with valid/ready handshakes on both sides.
- Owns the architectural status-flag register {minus, zero, carry}.

---
 rtl/nrisc_exec_pkg.sv | 29 ++
 rtl/nrisc_exec_perf.sv | 29 ++
 rtl/nrisc_ula_exec_stage.sv | 121 ++++++++++++
 tb/tb_nrisc_ula_exec_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_exec_pkg.sv
// Purpose: shared constants for the nRISC execute stage (ULA control codes, flag bit positions).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: CTRL_W/FLAG_W widths, ULA control codes, flag bit indices within {minus, zero, carry}.

package nrisc_exec_pkg;

   localparam int CTRL_W = 4;
   localparam int FLAG_W = 3;

   // ULA control codes
   localparam logic [CTRL_W-1:0] ADD  = 4'h0;
   localparam logic [CTRL_W-1:0] SUB  = 4'h1;
   localparam logic [CTRL_W-1:0] AND  = 4'h2;
   localparam logic [CTRL_W-1:0] NAND = 4'h3;
   localparam logic [CTRL_W-1:0] OR   = 4'h4;
   localparam logic [CTRL_W-1:0] XOR  = 4'h6;
   localparam logic [CTRL_W-1:0] SHR  = 4'h8;
   localparam logic [CTRL_W-1:0] ROTR = 4'h9;
   localparam logic [CTRL_W-1:0] SAR  = 4'hA;
   localparam logic [CTRL_W-1:0] SHL  = 4'hC;
   localparam logic [CTRL_W-1:0] ROTL = 4'hE;

   // Bit positions inside the {minus, zero, carry} flag vector
   localparam int MINUS = 2;
   localparam int ZERO  = 1;
   localparam int CARRY = 0;

endpackage

// File: rtl/nrisc_exec_perf.sv
// Purpose: completed-operation and E1-stall performance counters for the execute stage.
// Latency: counters reflect an event one edge after it is presented.
// Backpressure: none; pure event counting, both counters wrap and clear only on rst.
// Ports: clk, rst (sync, active-high), op_done/stall event strobes, perf_ops/perf_stall counts.

module nrisc_exec_perf
   import nrisc_exec_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             op_done,
   input  logic             stall,
   output logic [CNT_W-1:0] perf_ops,
   output logic [CNT_W-1:0] perf_stall
);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops   <= '0;
         perf_stall <= '0;
      end else begin
         if (op_done) perf_ops   <= perf_ops + 1'b1;
         if (stall)   perf_stall <= perf_stall + 1'b1;
      end
   end

endmodule

// File: rtl/nrisc_ula_exec_stage.sv
// Purpose: execute stage; E1 register drives the combinational ULA, result/flags captured into writeback.
// Latency: op accepted at edge N is presented on out_valid after edge N+1; 1 op/cycle at full rate.
// Backpressure: out_valid & ~out_ready holds the output; E1 then holds and in_ready drops when E1 is full.
// Ports: clk/rst (sync, active-high), flush, in_* upstream handshake + decoded op, ula_* to/from ULA,
//        out_* writeback handshake, flags_q architectural {minus, zero, carry}, perf_ops/perf_stall.
// Option: NRISC_EXEC_PERF_EN builds the performance counters; otherwise both outputs are tied to 0.

module nrisc_ula_exec_stage
   import nrisc_exec_pkg::*;
#(
   parameter int TAM   = 16,
   parameter int REG_W = 4,
   parameter int CNT_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TAM-1:0]    in_a,
   input  logic [TAM-1:0]    in_b,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [REG_W-1:0]  in_dest,
   input  logic              in_flag_we,
   output logic [TAM-1:0]    ula_a,
   output logic [TAM-1:0]    ula_b,
   output logic [CTRL_W-1:0] ula_ctrl,
   input  logic [TAM-1:0]    ula_out,
   input  logic [FLAG_W-1:0] ula_flags,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAM-1:0]    out_data,
   output logic [REG_W-1:0]  out_dest,
   output logic [FLAG_W-1:0] flags_q,
   output logic [CNT_W-1:0]  perf_ops,
   output logic [CNT_W-1:0]  perf_stall
);

   logic              e1_valid;
   logic [TAM-1:0]    e1_a;
   logic [TAM-1:0]    e1_b;
   logic [CTRL_W-1:0] e1_ctrl;
   logic [REG_W-1:0]  e1_dest;
   logic              e1_flag_we;

   logic e1_adv;
   logic e1_move;
   logic take;

   // e1_adv is the pure pipeline condition; e1_move additionally blocks writes
   // into the output/flag registers on a flush edge.
   assign e1_adv   = e1_valid & (~out_valid | out_ready);
   assign e1_move  = e1_adv & ~flush;
   assign in_ready = ~flush & (~e1_valid | e1_adv);
   assign take     = in_valid & in_ready;

   // ULA inputs come straight from E1 and keep their last value while E1 is empty
   assign ula_a    = e1_a;
   assign ula_b    = e1_b;
   assign ula_ctrl = e1_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         e1_valid   <= 1'b0;
         e1_a       <= '0;
         e1_b       <= '0;
         e1_ctrl    <= '0;
         e1_dest    <= '0;
         e1_flag_we <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_dest   <= '0;
         flags_q    <= '0;
      end else begin
         if (take) begin
            e1_a       <= in_a;
            e1_b       <= in_b;
            e1_ctrl    <= in_ctrl;
            e1_dest    <= in_dest;
            e1_flag_we <= in_flag_we;
         end

         if (flush)       e1_valid <= 1'b0;
         else if (take)   e1_valid <= 1'b1;
         else if (e1_adv) e1_valid <= 1'b0;

         if (e1_move) begin
            out_data <= ula_out;
            out_dest <= e1_dest;
         end

         if (flush)                       out_valid <= 1'b0;
         else if (e1_adv)                 out_valid <= 1'b1;
         else if (out_valid && out_ready) out_valid <= 1'b0;

         if (e1_move && e1_flag_we) flags_q <= ula_flags;
      end
   end

`ifdef NRISC_EXEC_PERF_EN
   logic op_done;
   logic stall;

   // A handshake coincident with flush still completes the op
   assign op_done = out_valid & out_ready;
   assign stall   = e1_valid & ~e1_adv & ~flush;

   nrisc_exec_perf #(.CNT_W(CNT_W)) u_perf (
      .clk        (clk),
      .rst        (rst),
      .op_done    (op_done),
      .stall      (stall),
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall)
   );
`else
   assign perf_ops   = '0;
   assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_nrisc_ula_exec_stage.sv
// Purpose: self-checking bench for nrisc_ula_exec_stage with a behavioural 16-bit ULA.
// Latency: n/a.
// Backpressure: n/a.

module tb_nrisc_ula_exec_stage;
   import nrisc_exec_pkg::*;

   localparam int TAM   = 16;
   localparam int REG_W = 4;
   localparam int CNT_W = 32;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [TAM-1:0]    in_a;
   logic [TAM-1:0]    in_b;
   logic [CTRL_W-1:0] in_ctrl;
   logic [REG_W-1:0]  in_dest;
   logic              in_flag_we;
   logic [TAM-1:0]    ula_a;
   logic [TAM-1:0]    ula_b;
   logic [CTRL_W-1:0] ula_ctrl;
   logic [TAM-1:0]    ula_out;
   logic [FLAG_W-1:0] ula_flags;
   logic              out_valid;
   logic              out_ready;
   logic [TAM-1:0]    out_data;
   logic [REG_W-1:0]  out_dest;
   logic [FLAG_W-1:0] flags_q;
   logic [CNT_W-1:0]  perf_ops;
   logic [CNT_W-1:0]  perf_stall;

   int errors = 0;
   int checks = 0;

   nrisc_ula_exec_stage #(.TAM(TAM), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_ctrl    (in_ctrl),
      .in_dest    (in_dest),
      .in_flag_we (in_flag_we),
      .ula_a      (ula_a),
      .ula_b      (ula_b),
      .ula_ctrl   (ula_ctrl),
      .ula_out    (ula_out),
      .ula_flags  (ula_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_dest   (out_dest),
      .flags_q    (flags_q),
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ULA: returns {minus, zero, carry, result}; carry only from ADD/SUB (borrow).
   function automatic logic [18:0] ula_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] c);
      logic [16:0] w;
      logic [15:0] r;
      logic        cy;
      logic [4:0]  s;
      s  = {1'b0, b[3:0]};
      cy = 1'b0;
      r  = 16'h0000;
      w  = 17'h0;
      case (c)
         ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; cy = w[16]; end
         SUB:  begin r = a - b; cy = (a < b); end
         AND:  r = a & b;
         NAND: r = ~(a & b);
         OR:   r = a | b;
         XOR:  r = a ^ b;
         SHR:  r = a >> s;
         SAR:  r = 16'($signed(a) >>> s);
         SHL:  r = a << s;
         ROTR: r = (a >> s) | (a << (5'd16 - s));
         ROTL: r = (a << s) | (a >> (5'd16 - s));
         default: r = 16'h0000;
      endcase
      return {r[15], (r == 16'h0000), cy, r};
   endfunction

   always_comb {ula_flags, ula_out} = ula_fn(ula_a, ula_b, ula_ctrl);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  ctrl;
      logic [3:0]  dest;
      logic        we;
      logic        ordy;
      logic        chk_rdy;
      logic        rdy;
      logic        ov;
      logic [15:0] data;
      logic [3:0]  odest;
      logic [2:0]  flags;
      int          ops;
      int          stall;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic fl, input logic iv,
                               input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic we, input logic ordy,
                               input logic cr, input logic rdy, input logic ov,
                               input logic [15:0] data, input logic [3:0] od,
                               input logic [2:0] f, input int ops, input int st);
      vec_t v;
      v.rst = r; v.flush = fl; v.iv = iv; v.a = a; v.b = b; v.ctrl = c; v.dest = d;
      v.we = we; v.ordy = ordy; v.chk_rdy = cr; v.rdy = rdy; v.ov = ov; v.data = data;
      v.odest = od; v.flags = f; v.ops = ops; v.stall = st;
      return v;
   endfunction

   function automatic logic [31:0] perf_exp(input int v);
`ifdef NRISC_EXEC_PERF_EN
      return 32'(v);
`else
      return 32'(v - v);
`endif
   endfunction

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dest;
      logic        we;
      logic [2:0]  flags;
   } exp_t;

   vec_t tbl[25];
   exp_t q[$];
   logic [3:0] codes[11];

   initial begin
      exp_t        e;
      logic [18:0] u;
      logic [2:0]  exp_flags;
      int          n_ops;
      int          n_stall;

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ctrl = '0;
      in_dest = '0; in_flag_we = 1'b0; out_ready = 1'b0;

      //            rst fl iv a        b        ctrl dst we ordy  cr rdy  ov data     dst flags  ops st
      tbl[0]  = mk(1, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 0,    0, 0,   0, 16'h0,    0, 3'b000, 0, 0);
      tbl[1]  = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0,    0, 3'b000, 0, 0);
      tbl[2]  = mk(0, 0, 1, 16'h00F0,16'h0F00,AND,  3, 1, 1,    1, 1,   0, 16'h0,    0, 3'b000, 0, 0);
      tbl[3]  = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   1, 16'h0,    3, 3'b010, 0, 0);
      tbl[4]  = mk(0, 0, 1, 16'h00F0,16'h0F00,OR,   1, 1, 1,    1, 1,   0, 16'h0,    3, 3'b010, 1, 0);
      tbl[5]  = mk(0, 0, 1, 16'hFFFF,16'h00FF,XOR,  2, 1, 1,    1, 1,   1, 16'h0FF0, 1, 3'b000, 1, 0);
      tbl[6]  = mk(0, 0, 1, 16'h0001,16'h0004,SHL,  4, 1, 1,    1, 1,   1, 16'hFF00, 2, 3'b100, 2, 0);
      tbl[7]  = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   1, 16'h0010, 4, 3'b000, 3, 0);
      tbl[8]  = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0010, 4, 3'b000, 4, 0);
      tbl[9]  = mk(0, 0, 1, 16'h0001,16'h0002,ADD,  5, 1, 0,    1, 1,   0, 16'h0010, 4, 3'b000, 4, 0);
      tbl[10] = mk(0, 0, 1, 16'h0005,16'h0003,SUB,  6, 1, 0,    1, 1,   1, 16'h0003, 5, 3'b000, 4, 0);
      tbl[11] = mk(0, 0, 1, 16'h0007,16'h0008,ADD,  7, 1, 0,    1, 0,   1, 16'h0003, 5, 3'b000, 4, 1);
      tbl[12] = mk(0, 0, 1, 16'h0007,16'h0008,ADD,  7, 1, 0,    1, 0,   1, 16'h0003, 5, 3'b000, 4, 2);
      tbl[13] = mk(0, 0, 1, 16'h0007,16'h0008,ADD,  7, 1, 0,    1, 0,   1, 16'h0003, 5, 3'b000, 4, 3);
      tbl[14] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   1, 16'h0002, 6, 3'b000, 5, 3);
      tbl[15] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0002, 6, 3'b000, 6, 3);
      tbl[16] = mk(0, 0, 1, 16'h0F0F,16'hF0F0,AND,  8, 0, 1,    1, 1,   0, 16'h0002, 6, 3'b000, 6, 3);
      tbl[17] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   1, 16'h0000, 8, 3'b000, 6, 3);
      tbl[18] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0000, 8, 3'b000, 7, 3);
      tbl[19] = mk(0, 0, 1, 16'hFFFF,16'h0001,ADD,  9, 1, 0,    1, 1,   0, 16'h0000, 8, 3'b000, 7, 3);
      tbl[20] = mk(0, 0, 1, 16'h0001,16'h0002,SUB, 10, 1, 0,    1, 1,   1, 16'h0000, 9, 3'b011, 7, 3);
      tbl[21] = mk(0, 1, 1, 16'h0001,16'h0002,OR,  11, 1, 1,    1, 0,   0, 16'h0000, 9, 3'b011, 8, 3);
      tbl[22] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0000, 9, 3'b011, 8, 3);
      tbl[23] = mk(1, 1, 1, 16'h0001,16'h0002,OR,  11, 1, 1,    1, 0,   0, 16'h0000, 0, 3'b000, 0, 0);
      tbl[24] = mk(0, 0, 0, 16'h0,   16'h0,   ADD,  0, 0, 1,    1, 1,   0, 16'h0000, 0, 3'b000, 0, 0);

      @(posedge clk); #1;
      for (int i = 0; i < 25; i++) begin
         rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
         in_a = tbl[i].a; in_b = tbl[i].b; in_ctrl = tbl[i].ctrl; in_dest = tbl[i].dest;
         in_flag_we = tbl[i].we; out_ready = tbl[i].ordy;
         #1;
         if (tbl[i].chk_rdy) chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         @(posedge clk); #1;
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("row%0d out_data", i),  32'(out_data),  32'(tbl[i].data));
         chk($sformatf("row%0d out_dest", i),  32'(out_dest),  32'(tbl[i].odest));
         chk($sformatf("row%0d flags_q", i),   32'(flags_q),   32'(tbl[i].flags));
         chk($sformatf("row%0d perf_ops", i),  perf_ops,       perf_exp(tbl[i].ops));
         chk($sformatf("row%0d perf_stall", i), perf_stall,    perf_exp(tbl[i].stall));
      end

      // Randomized traffic against a transaction-level scoreboard
      codes = '{ADD, SUB, AND, NAND, OR, XOR, SHR, ROTR, SAR, SHL, ROTL};
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_flags = 3'b000;
      n_ops = 0;
      n_stall = 0;
      for (int cyc = 0; cyc < 3030; cyc++) begin
         if (cyc < 3000) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid   = 1'b0;
            out_ready  = 1'b1;
         end
         in_a       = 16'($urandom);
         in_b       = 16'($urandom);
         in_ctrl    = codes[$urandom_range(0, 10)];
         in_dest    = 4'($urandom);
         in_flag_we = 1'($urandom);
         #1;
         // Two ops in flight means E1 and the output are both occupied
         if (q.size() == 2 && !out_ready) n_stall++;
         chk("occupancy<=2", 32'(q.size() <= 2), 32'd1);
         if (out_valid && out_ready) begin
            chk("valid with op in flight", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               if (e.we) exp_flags = e.flags;
               chk("rand out_data", 32'(out_data), 32'(e.data));
               chk("rand out_dest", 32'(out_dest), 32'(e.dest));
               chk("rand flags_q",  32'(flags_q),  32'(exp_flags));
            end
            n_ops++;
         end
         if (in_valid && in_ready) begin
            u = ula_fn(in_a, in_b, in_ctrl);
            e.data  = u[15:0];
            e.flags = u[18:16];
            e.dest  = in_dest;
            e.we    = in_flag_we;
            q.push_back(e);
         end
         @(posedge clk); #1;
      end
      chk("drained", 32'(q.size()), 32'd0);
      chk("rand out_valid idle", 32'(out_valid), 32'd0);
      chk("rand perf_ops",   perf_ops,   perf_exp(n_ops));
      chk("rand perf_stall", perf_stall, perf_exp(n_stall));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
